// File: rtl/fb_frame_writer.sv
// Raster-order pixel writer for a double-buffered frame RAM.
// Fills the back bank and swaps banks on the first VS falling edge after a complete frame.
module fb_frame_writer #(
  parameter int H_PIX = 160,
  parameter int V_PIX = 120,
  parameter int DW    = 8,
  parameter int AW    = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  input  logic          i_sof,
  input  logic          i_vs,
  output logic          o_we,
  output logic [AW-1:0] o_waddr,
  output logic [DW-1:0] o_wdata,
  output logic          o_disp_bank,
  output logic          o_frame_done,
  output logic          o_sof_err
);

  // state     | meaning
  // IDLE      | back bank empty, discard pixels until a start-of-frame beat
  // WRITE     | filling back bank in raster order
  // WAIT_SWAP | back bank complete, stalled until the next VS falling edge
  typedef enum logic [1:0] {IDLE, WRITE, WAIT_SWAP} state_t;

  localparam int            FRAME   = H_PIX * V_PIX;
  localparam logic [AW-1:0] FRAME_A = AW'(FRAME);
  localparam logic [AW-1:0] LAST_A  = AW'(FRAME - 1);
  localparam logic [AW-1:0] ONE_A   = AW'(1);

  state_t        state, state_nxt;
  logic [AW-1:0] pix;
  logic [AW-1:0] wptr;
  logic [AW-1:0] base;
  logic          vs_q;
  logic          accept;
  logic          vs_fall;
  logic          wr_en;
  logic          wr_restart;
  logic          sof_err_nxt;
  logic          swap;

  assign accept  = i_valid & o_ready;
  assign vs_fall = vs_q & ~i_vs;
  // The write bank is always the one the display is not reading.
  assign base    = o_disp_bank ? '0 : FRAME_A;

  always_comb begin
    state_nxt   = state;
    wr_en       = 1'b0;
    wr_restart  = 1'b0;
    sof_err_nxt = 1'b0;
    swap        = 1'b0;
    case (state)
      IDLE: begin
        if (accept && i_sof) begin
          wr_en      = 1'b1;
          wr_restart = 1'b1;
          state_nxt  = WRITE;
        end
      end
      WRITE: begin
        if (accept) begin
          wr_en = 1'b1;
          // A restart wins over completion, even on the last pixel.
          if (i_sof) begin
            wr_restart  = 1'b1;
            sof_err_nxt = 1'b1;
          end else if (pix == LAST_A) begin
            state_nxt = WAIT_SWAP;
          end
        end
      end
      WAIT_SWAP: begin
        if (vs_fall) begin
          swap      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      o_ready      <= 1'b0;
      vs_q         <= 1'b1;
      pix          <= '0;
      wptr         <= '0;
      o_we         <= 1'b0;
      o_waddr      <= '0;
      o_wdata      <= '0;
      o_disp_bank  <= 1'b0;
      o_frame_done <= 1'b0;
      o_sof_err    <= 1'b0;
    end else begin
      state        <= state_nxt;
      o_ready      <= (state_nxt != WAIT_SWAP);
      vs_q         <= i_vs;
      o_we         <= wr_en;
      o_frame_done <= swap;
      o_sof_err    <= sof_err_nxt;
      // wptr tracks base+pix so the address needs only an incrementer.
      if (wr_en) begin
        o_wdata <= i_data;
        if (wr_restart) begin
          o_waddr <= base;
          wptr    <= base + ONE_A;
          pix     <= ONE_A;
        end else begin
          o_waddr <= wptr;
          wptr    <= wptr + ONE_A;
          pix     <= pix + ONE_A;
        end
      end
      if (swap) begin
        o_disp_bank <= ~o_disp_bank;
        pix         <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fb_frame_writer.sv
// Scoreboard bench for fb_frame_writer: the driver queues expected RAM writes,
// a negedge monitor pops and compares every o_we beat.
module tb_fb_frame_writer;

  localparam int FRAME = 19200;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [7:0]  i_data = '0;
  logic        i_sof = 1'b0;
  logic        i_vs = 1'b1;
  logic        o_we;
  logic [15:0] o_waddr;
  logic [7:0]  o_wdata;
  logic        o_disp_bank;
  logic        o_frame_done;
  logic        o_sof_err;

  fb_frame_writer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_sof(i_sof), .i_vs(i_vs), .o_we(o_we),
    .o_waddr(o_waddr), .o_wdata(o_wdata), .o_disp_bank(o_disp_bank),
    .o_frame_done(o_frame_done), .o_sof_err(o_sof_err)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  logic [23:0] sb[$];

  always @(negedge i_clk) begin
    logic [23:0] exp_w;
    if (o_frame_done) done_cnt++;
    if (o_sof_err) err_cnt++;
    if (o_we) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%0h, no write expected", o_waddr, o_wdata);
      end else begin
        exp_w = sb.pop_front();
        if ({o_waddr, o_wdata} !== exp_w) begin
          errors++;
          $display("FAIL write: addr=%0d data=%0h, expected addr=%0d data=%0h",
                   o_waddr, o_wdata, exp_w[23:8], exp_w[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic beat(input logic sof, input logic [7:0] d, input logic exp_wr,
                      input logic [15:0] exp_addr);
    @(negedge i_clk);
    i_valid = 1'b1;
    i_sof   = sof;
    i_data  = d;
    if (exp_wr) sb.push_back({exp_addr, d});
  endtask

  task automatic idle();
    @(negedge i_clk);
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  initial begin
    logic [15:0] a;
    // reset
    #1 i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    check("rst_ready", o_ready, 0);
    check("rst_we", o_we, 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("post_rst_ready", o_ready, 1);
    check("post_rst_bank", o_disp_bank, 0);
    check("post_rst_done", o_frame_done, 0);
    check("post_rst_soferr", o_sof_err, 0);

    // pre-SOF beats are discarded, then a continuous frame into bank 1
    for (int k = 0; k < 5; k++) beat(1'b0, 8'hE0 + 8'(k), 1'b0, 16'd0);
    for (int k = 0; k < FRAME; k++) begin
      a = 16'(k);
      beat(k == 0, a[7:0], 1'b1, 16'(FRAME + k));
    end
    idle();
    check("full_ready_low", o_ready, 0);
    check("full_bank_before_vs", o_disp_bank, 0);
    // beats offered while waiting for the swap are ignored
    beat(1'b1, 8'h55, 1'b0, 16'd0);
    beat(1'b0, 8'h66, 1'b0, 16'd0);
    idle();
    i_vs = 1'b0;
    @(negedge i_clk);
    check("swap1_done", o_frame_done, 1);
    check("swap1_bank", o_disp_bank, 1);
    check("swap1_ready", o_ready, 1);
    i_vs = 1'b1;
    @(negedge i_clk);
    check("swap1_done_pulse", o_frame_done, 0);
    check("swap1_count", done_cnt, 1);

    // bank 0 frame with input gaps, early SOF at beat 100, VS edge mid-frame
    for (int n = 0; n < FRAME + 100; n++) begin
      int j;
      j = (n < 100) ? n : n - 100;
      if (n == 5000) i_vs = 1'b0;
      if (n == 5005) i_vs = 1'b1;
      a = 16'(j);
      beat(j == 0, a[7:0], 1'b1, 16'(j));
      if ((n % 4) == 3) idle();
    end
    idle();
    check("early_sof_pulses", err_cnt, 1);
    check("gap_no_swap_in_write", done_cnt, 1);
    check("gap_ready_low", o_ready, 0);
    i_vs = 1'b0;
    @(negedge i_clk);
    check("swap2_bank", o_disp_bank, 0);
    check("swap2_done", o_frame_done, 1);
    i_vs = 1'b1;
    @(negedge i_clk);

    // bank 1 frame whose last beat coincides with a VS falling edge
    for (int k = 0; k < FRAME; k++) begin
      a = 16'(k ^ 8'h5A);
      if (k == FRAME - 1) i_vs = 1'b0;
      beat(k == 0, a[7:0], 1'b1, 16'(FRAME + k));
    end
    repeat (4) idle();
    check("coincident_vs_no_swap_bank", o_disp_bank, 0);
    check("coincident_vs_no_swap_cnt", done_cnt, 2);
    check("coincident_ready_low", o_ready, 0);
    i_vs = 1'b1;
    @(negedge i_clk);
    i_vs = 1'b0;
    @(negedge i_clk);
    check("swap3_done", o_frame_done, 1);
    check("swap3_bank", o_disp_bank, 1);
    i_vs = 1'b1;
    @(negedge i_clk);

    // reset in the middle of a bank 0 frame
    for (int k = 0; k < 5000; k++) begin
      a = 16'(k);
      beat(k == 0, a[7:0], 1'b1, 16'(k));
    end
    idle();
    #2 i_rst = 1'b1;
    #1;
    check("midrst_bank", o_disp_bank, 0);
    check("midrst_we", o_we, 0);
    check("midrst_ready", o_ready, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("midrst_idle_ready", o_ready, 1);
    beat(1'b0, 8'h11, 1'b0, 16'd0);
    beat(1'b1, 8'hAB, 1'b1, 16'(FRAME));
    beat(1'b0, 8'hCD, 1'b1, 16'(FRAME + 1));
    idle();
    idle();
    check("final_queue_empty", sb.size(), 0);
    check("final_swap_count", done_cnt, 3);
    check("final_soferr_count", err_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
